// File: rtl/avmm_capture_slave.sv
// avmm_capture_slave: Avalon-MM capture buffer (lower half) and CSR window (upper half).
// Optional macro AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN adds LFSR-driven waitrequest stalls.
module avmm_capture_slave #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int BURST_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    input  logic [BURST_W-1:0]  avs_burstcount,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                irq
);
    localparam int D = 1 << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] DFULL = ADDR_W'(D);
    localparam logic [DATA_W-1:0] ID    = DATA_W'(32'hB9FC_0001);

    typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [BURST_W-1:0] blen;
    logic [BURST_W-1:0] cnt;
    logic [BURST_W-1:0] dcnt;
    logic               enable;
    logic               irq_en;
    logic               overflow;
    logic [ADDR_W-1:0]  wordcnt;
    logic [DATA_W-1:0]  mem [D];
    logic [DATA_W-1:0]  mem_q;
    logic               s1_valid;
    logic               s1_csr;
    logic [1:0]         s1_idx;
    logic [DATA_W-1:0]  csr_rdata;
    logic               full;
    logic [BURST_W-1:0] blen_in;
    logic               wacc;
    logic               racc;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  raddr;
    logic               buf_wr;
    logic               store;
    logic               bp_n;

    // Beat n of a burst: buffer bursts wrap inside the buffer, CSR bursts inside 4 regs.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0]  a,
        input logic [BURST_W-1:0] n
    );
        logic [ADDR_W-1:0] r;
        r = a;
        if (a[ADDR_W-1])
            r[1:0] = a[1:0] + 2'(n);
        else
            r[ADDR_W-2:0] = a[ADDR_W-2:0] + (ADDR_W-1)'(n);
        return r;
    endfunction

    assign full    = (wordcnt == DFULL);
    assign blen_in = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    assign wacc    = avs_write & ~avs_waitrequest & (state != RBURST);
    assign racc    = avs_read & ~avs_write & ~avs_waitrequest & (state == IDLE);
    assign waddr   = (state == IDLE) ? avs_address : beat_addr(base, cnt);
    assign raddr   = beat_addr(base, cnt);
    assign buf_wr  = wacc & ~waddr[ADDR_W-1];
    assign store   = buf_wr & enable & ~full;

`ifdef AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_n;
    assign lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign bp_n   = lfsr_n[0];

    // Free-running stall pattern generator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= lfsr_n;
    end
`else
    assign bp_n = 1'b0;
`endif

    // CSR read mux for the second read pipeline stage.
    always_comb begin
        csr_rdata = '0;
        unique case (s1_idx)
            2'd0: csr_rdata = DATA_W'({irq_en, 1'b0, enable});
            2'd1: csr_rdata = DATA_W'({full, overflow});
            2'd2: csr_rdata = DATA_W'(wordcnt);
            2'd3: csr_rdata = ID;
        endcase
    end

    // Buffer RAM: masked byte writes and synchronous read (not reset).
    always_ff @(posedge clk) begin
        if (store) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (avs_byteenable[i])
                    mem[waddr[ADDR_W-2:0]][i*8 +: 8] <= avs_writedata[i*8 +: 8];
            end
        end
        mem_q <= mem[raddr[ADDR_W-2:0]];
    end

    // Burst FSM, CSR state, capture counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            base              <= '0;
            blen              <= '0;
            cnt               <= '0;
            dcnt              <= '0;
            enable            <= 1'b0;
            irq_en            <= 1'b0;
            overflow          <= 1'b0;
            wordcnt           <= '0;
            s1_valid          <= 1'b0;
            s1_csr            <= 1'b0;
            s1_idx            <= '0;
            avs_waitrequest   <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            avs_waitrequest   <= bp_n;
            s1_valid          <= 1'b0;
            avs_readdatavalid <= s1_valid;
            avs_readdata      <= s1_csr ? csr_rdata : mem_q;
            irq               <= irq_en & (overflow | full);

            if (store)
                wordcnt <= wordcnt + 1'b1;
            if (buf_wr & enable & full)
                overflow <= 1'b1;
            if (wacc & waddr[ADDR_W-1] & (waddr[1:0] == 2'd0)) begin
                enable <= avs_writedata[0];
                irq_en <= avs_writedata[2];
                if (avs_writedata[1]) begin
                    wordcnt  <= '0;
                    overflow <= 1'b0;
                end
            end

            unique case (state)
                IDLE: begin
                    if (wacc) begin
                        base <= avs_address;
                        blen <= blen_in;
                        cnt  <= BURST_W'(1);
                        if (blen_in != BURST_W'(1))
                            state <= WBURST;
                    end else if (racc) begin
                        base            <= avs_address;
                        blen            <= blen_in;
                        cnt             <= '0;
                        dcnt            <= '0;
                        state           <= RBURST;
                        avs_waitrequest <= 1'b1;
                    end
                end
                WBURST: begin
                    if (wacc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == blen)
                            state <= IDLE;
                    end
                end
                RBURST: begin
                    avs_waitrequest <= 1'b1;
                    if (cnt != blen) begin
                        s1_valid <= 1'b1;
                        s1_csr   <= raddr[ADDR_W-1];
                        s1_idx   <= raddr[1:0];
                        cnt      <= cnt + 1'b1;
                    end
                    if (avs_readdatavalid) begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == blen - 1'b1) begin
                            state           <= IDLE;
                            avs_waitrequest <= bp_n;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_capture_slave.sv
// tb_avmm_capture_slave: directed vectors for the Avalon-MM capture slave.
// Define AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN to also exercise random stalls.
module tb_avmm_capture_slave;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 4;
    localparam int D  = 512;
    localparam logic [AW-1:0] CSR = 10'h200;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [DW-1:0] avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [BW-1:0] avs_burstcount;
    logic          avs_waitrequest;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic          irq;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [31:0] v;

    avmm_capture_slave #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic wait_accept(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (avs_waitrequest && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_tmo"}, 32'(t >= 200), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                            input logic [3:0] be);
        int n;
        n = (bc == 0) ? 1 : int'(bc);
        avs_address    = addr;
        avs_burstcount = bc;
        avs_byteenable = be;
        avs_write      = 1'b1;
        for (int b = 0; b < n; b++) begin
            avs_writedata = wbuf[b];
            wait_accept("wr");
        end
        avs_write = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                            input int abort_k);
        int n;
        int got;
        int firstk;
        int lastk;
        n      = (bc == 0) ? 1 : int'(bc);
        got    = 0;
        firstk = 0;
        lastk  = 0;
        avs_address    = addr;
        avs_burstcount = bc;
        avs_read       = 1'b1;
        wait_accept("rd");
        avs_read = 1'b0;
        for (int k = 1; k <= 40 && got < n; k++) begin
            @(posedge clk);
            #1;
            if (abort_k != 0 && k == abort_k) begin
                check("pre_rst_rdv", 32'(avs_readdatavalid), 32'd1);
                reset = 1'b1;
                #1;
                check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
                check("rst_wait", 32'(avs_waitrequest), 32'd0);
                check("rst_rdata", avs_readdata, 32'd0);
                return;
            end
            if (avs_readdatavalid) begin
                if (got == 0) firstk = k;
                lastk     = k;
                rbuf[got] = avs_readdata;
                got++;
            end
        end
        check("rd_beats", got, n);
        check("rd_lat", firstk, 32'd2);
        check("rd_b2b", lastk - firstk + 1, n);
        check("rd_wait_busy", 32'(avs_waitrequest), 32'd1);
        @(posedge clk);
        #1;
`ifndef AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN
        check("rd_wait_free", 32'(avs_waitrequest), 32'd0);
`endif
    endtask

    task automatic csr_wr(input logic [1:0] idx, input logic [31:0] d);
        wbuf[0] = d;
        wr_burst(CSR | AW'(idx), 4'd1, 4'hF);
    endtask

    task automatic csr_rd(input logic [1:0] idx, output logic [31:0] d);
        rd_burst(CSR | AW'(idx), 4'd1, 0);
        d = rbuf[0];
    endtask

    initial begin
        reset          = 1'b1;
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        avs_burstcount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait0", 32'(avs_waitrequest), 32'd0);
        check("rst_rdv0", 32'(avs_readdatavalid), 32'd0);
        check("rst_rdata0", avs_readdata, 32'd0);
        check("rst_irq0", 32'(irq), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        csr_rd(2'd0, v); check("ctrl_rst", v, 32'd0);
        csr_rd(2'd2, v); check("wcnt_rst", v, 32'd0);

        csr_wr(2'd0, 32'd1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr_burst(10'd0, 4'd4, 4'hF);
        csr_rd(2'd2, v); check("wcnt4", v, 32'd4);
        rd_burst(10'd0, 4'd4, 0);
        for (int i = 0; i < 4; i++) check("rd4", rbuf[i], 32'(i + 1));

        wbuf[0] = 32'hFFFF_FFFF;
        wr_burst(10'd8, 4'd1, 4'hF);
        wbuf[0] = 32'h0;
        wr_burst(10'd8, 4'd1, 4'b0010);
        rd_burst(10'd8, 4'd1, 0);
        check("be_mask", rbuf[0], 32'hFFFF_00FF);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'h10 + 32'(i);
        wr_burst(AW'(D - 2), 4'd4, 4'hF);
        rd_burst(AW'(D - 2), 4'd4, 0);
        for (int i = 0; i < 4; i++) check("wrap_rd", rbuf[i], 32'h10 + 32'(i));
        rd_burst(10'd0, 4'd2, 0);
        check("wrap_w0", rbuf[0], 32'h12);
        check("wrap_w1", rbuf[1], 32'h13);

        rd_burst(CSR | 10'd2, 4'd4, 0);
        check("csrb_wcnt", rbuf[0], 32'd10);
        check("csrb_id", rbuf[1], 32'hB9FC_0001);
        check("csrb_ctrl", rbuf[2], 32'd1);
        check("csrb_stat", rbuf[3], 32'd0);

        rd_burst(10'd3, 4'd0, 0);
        check("bc0_rd", rbuf[0], 32'd4);

        csr_wr(2'd0, 32'd7);
        csr_rd(2'd2, v); check("clr_wcnt", v, 32'd0);
        csr_rd(2'd1, v); check("clr_stat", v, 32'd0);
        for (int i = 0; i <= D; i++) begin
            wbuf[0] = 32'h100 + 32'(i);
            wr_burst(AW'(i % D), 4'd1, 4'hF);
        end
        csr_rd(2'd2, v); check("full_wcnt", v, 32'(D));
        csr_rd(2'd1, v); check("full_stat", v, 32'd3);
        check("full_irq", 32'(irq), 32'd1);
        rd_burst(10'd0, 4'd1, 0);
        check("ovf_drop", rbuf[0], 32'h100);
        csr_wr(2'd0, 32'd7);
        csr_rd(2'd2, v); check("clr2_wcnt", v, 32'd0);
        check("clr2_irq", 32'(irq), 32'd0);
        csr_rd(2'd1, v); check("clr2_stat", v, 32'd0);

        csr_wr(2'd0, 32'd0);
        wbuf[0] = 32'hDEAD;
        wr_burst(10'd5, 4'd1, 4'hF);
        csr_rd(2'd2, v); check("dis_wcnt", v, 32'd0);
        csr_rd(2'd1, v); check("dis_stat", v, 32'd0);
        rd_burst(10'd5, 4'd1, 0);
        check("dis_data", rbuf[0], 32'h105);
        csr_rd(2'd3, v); check("id", v, 32'hB9FC_0001);
        csr_wr(2'd2, 32'd7);
        csr_rd(2'd2, v); check("wcnt_ro", v, 32'd0);

        csr_wr(2'd0, 32'd1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        wr_burst(10'd32, 4'd4, 4'hF);
        rd_burst(10'd32, 4'd4, 3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd_burst(10'd32, 4'd4, 0);
        for (int i = 0; i < 4; i++) check("post_rst", rbuf[i], 32'hA0 + 32'(i));
        csr_rd(2'd0, v); check("post_rst_ctrl", v, 32'd0);

`ifdef AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN
        csr_wr(2'd0, 32'd3);
        for (int i = 0; i < 15; i++) wbuf[i] = 32'hC0 + 32'(i);
        wr_burst(10'd64, 4'd15, 4'hF);
        wbuf[0] = 32'hCF;
        wr_burst(10'd79, 4'd1, 4'hF);
        csr_rd(2'd2, v); check("bp_wcnt", v, 32'd16);
        rd_burst(10'd64, 4'd15, 0);
        for (int i = 0; i < 15; i++) check("bp_rd", rbuf[i], 32'hC0 + 32'(i));
        rd_burst(10'd79, 4'd1, 0);
        check("bp_rd15", rbuf[0], 32'hCF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/avmm_capture_slave.md
AVMM_CAPTURE_SLAVE -- requirements
Module: avmm_capture_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, Avalon data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 10, word address width; buffer depth D = 2^(ADDR_W-1) words.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width.
REQ-004 SHALL have a single clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 avs_address  in  ADDR_W  word address; bit ADDR_W-1 = 0 buffer, = 1 CSR.
REQ-008 avs_read  in  1  read command.
REQ-009 avs_write  in  1  write command/beat.
REQ-010 avs_writedata  in  DATA_W  write data.
REQ-011 avs_byteenable  in  DATA_W/8  byte lanes for buffer writes.
REQ-012 avs_burstcount  in  BURST_W  beats per burst; 0 treated as 1.
REQ-013 avs_waitrequest  out  1  stall; command/beat accepted only when low.
REQ-014 avs_readdata  out  DATA_W  read data.
REQ-015 avs_readdatavalid  out  1  readdata qualifier.
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 CSR map (address low 2 bits): 0 CTRL [0]=enable, [1]=clear (write-1 pulse, reads 0), [2]=irq_en; 1 STATUS [0]=overflow sticky, [1]=full; 2 WORDCNT; 3 ID = 32'hB9FC_0001.
REQ-018 FSM states IDLE, WBURST, RBURST; reset to IDLE.
REQ-019 IDLE: write accepted -> latch address/burstcount, perform beat 1, go WBURST if burstcount>1 else stay IDLE.
REQ-020 WBURST: each accepted beat uses address+n; after last beat -> IDLE; avs_read ignored.
REQ-021 IDLE: read accepted (write low) -> RBURST; waitrequest high throughout RBURST.
REQ-022 Read latency: first readdatavalid exactly 2 cycles after acceptance edge; remaining beats back-to-back; waitrequest low the cycle after the last beat.
REQ-023 read and write both high in IDLE: write wins, read dropped.
REQ-024 Buffer write stored only when enable=1 and WORDCNT<D; byteenable masks lanes; WORDCNT increments by 1 per stored beat.
REQ-025 Buffer write when WORDCNT==D: dropped, overflow set; writes with enable=0 dropped silently.
REQ-026 Burst address crossing buffer end wraps to word 0 within buffer region; CSR bursts wrap within 4 CSRs.
REQ-027 full = (WORDCNT==D); WORDCNT never exceeds D.
REQ-028 clear: WORDCNT<=0, overflow<=0 on the accepting edge; buffer contents unchanged.
REQ-029 CSR writes use writedata[2:0] only; writes to STATUS/WORDCNT/ID ignored.
REQ-030 irq = irq_en & (overflow | full), registered, 1 cycle after cause.
REQ-031 Buffer reads return stored data regardless of enable.

Reset
REQ-032 Reset SHALL force FSM IDLE, waitrequest 0, readdatavalid 0, readdata 0, irq 0, CTRL 0, overflow 0, WORDCNT 0, LFSR 8'hA5.
REQ-033 Reset mid-burst SHALL abort immediately; no further readdatavalid; buffer RAM not reset.

Configuration
REQ-034 Macro AVMM_CAPTURE_SLAVE_BACKPRESSURE_EN: defined -> 8-bit LFSR (x^8+x^6+x^5+x^4+1, advances each cycle) additionally asserts waitrequest in IDLE/WBURST when lfsr[0]=1; undefined -> waitrequest high only in RBURST.

Verification
REQ-035 CTRL=1; 4-beat write 0x1..0x4 at addr 0 -> WORDCNT=4; 4-beat read addr 0 -> readdatavalid 2 cycles later, 0x1,0x2,0x3,0x4 consecutive.
REQ-036 Write 0xFFFFFFFF then byteenable=4'b0010 data 0 same addr -> read 0xFFFF00FF.
REQ-037 D+1 writes with irq_en=1 -> WORDCNT=D, STATUS=3, irq=1; CTRL=3'b111 -> WORDCNT=0, irq=0.
REQ-038 Read ID -> 32'hB9FC_0001; enable=0 write -> WORDCNT unchanged.
REQ-039 Reset asserted during beat 2 of 4-beat read -> readdatavalid 0 immediately, next read returns correct data.
REQ-040 With BACKPRESSURE_EN, 16-beat write -> all 16 beats stored despite random waitrequest.
